// File: rtl/spram_ring_ctrl.sv
// Ring-buffer FIFO controller that time-shares one single-port RAM between a write and a read stream.
// Define SPRAM_RING_OUTREG_EN when the RAM has an output register (read latency 2, 3-entry output buffer).
module spram_ring_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  full,
  output logic                  empty
);

`ifdef SPRAM_RING_OUTREG_EN
  localparam int LAT        = 2;
  localparam int OBUF_DEPTH = 3;
`else
  localparam int LAT        = 1;
  localparam int OBUF_DEPTH = 2;
`endif
  localparam int CW = $clog2(OBUF_DEPTH + LAT + 1);
  localparam int PW = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  typedef enum logic {GRANT_READ = 1'b0, GRANT_WRITE = 1'b1} grant_t;

  logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  grant_t                last_grant;
  logic [LAT-1:0]        tag_pipe;
  logic [DATA_WIDTH-1:0] obuf_mem [OBUF_DEPTH];
  logic [PW-1:0]         obuf_head, obuf_tail;
  logic [CW-1:0]         obuf_cnt, inflight;
  logic                  rd_req, wr_req, rd_grant, wr_grant;
  logic                  obuf_push, obuf_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == {1'b1, {ADDR_WIDTH{1'b0}}});
  assign empty = (level == '0);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < LAT; i++) inflight = inflight + CW'(tag_pipe[i]);
  end

  // Reads are only issued when the output buffer is guaranteed room for every word in flight.
  always_comb begin
    rd_req   = !empty && ((obuf_cnt + inflight) < CW'(OBUF_DEPTH));
    wr_req   = s_valid && !full;
    rd_grant = 1'b0;
    wr_grant = 1'b0;
    if (!flush) begin
      if (wr_req && (!rd_req || last_grant == GRANT_READ)) wr_grant = 1'b1;
      else if (rd_req)                                      rd_grant = 1'b1;
    end
  end

  assign s_ready     = !flush && !full && !(rd_req && last_grant == GRANT_WRITE);
  assign ram_wr_en   = wr_grant;
  assign ram_addr    = wr_grant ? wr_ptr[ADDR_WIDTH-1:0] : rd_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = s_data;

  assign m_valid   = (obuf_cnt != '0);
  assign m_data    = obuf_mem[obuf_head];
  assign obuf_push = tag_pipe[LAT-1] && !flush;
  assign obuf_pop  = m_valid && m_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_grant <= GRANT_READ;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_grant <= GRANT_READ;
    end else begin
      if (wr_grant) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= GRANT_WRITE;
      end
      if (rd_grant) begin
        rd_ptr     <= rd_ptr + 1'b1;
        last_grant <= GRANT_READ;
      end
    end
  end

  // Each tag marks a RAM read whose data lands on ram_rd_data when it leaves the pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_pipe <= '0;
    end else if (flush) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= rd_grant;
      for (int i = 1; i < LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obuf_head <= '0;
      obuf_tail <= '0;
      obuf_cnt  <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf_mem[i] <= '0;
    end else if (flush) begin
      obuf_head <= '0;
      obuf_tail <= '0;
      obuf_cnt  <= '0;
    end else begin
      if (obuf_push) begin
        obuf_mem[obuf_tail] <= ram_rd_data;
        obuf_tail           <= ptr_next(obuf_tail);
      end
      if (obuf_pop) obuf_head <= ptr_next(obuf_head);
      if (obuf_push && !obuf_pop)      obuf_cnt <= obuf_cnt + 1'b1;
      else if (!obuf_push && obuf_pop) obuf_cnt <= obuf_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_spram_ring_ctrl.sv
// Self-checking bench for spram_ring_ctrl: behavioural RAM, queue scoreboard and randomized streams.
// Honours SPRAM_RING_OUTREG_EN for the RAM read latency and output buffer depth.
module tb_spram_ring_ctrl;
  localparam int AW    = 10;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef SPRAM_RING_OUTREG_EN
  localparam int LAT = 2;
  localparam int OB  = 3;
`else
  localparam int LAT = 1;
  localparam int OB  = 2;
`endif

  logic          clk, rst_n, flush, s_valid, s_ready, m_valid, m_ready;
  logic          ram_wr_en, full, empty;
  logic [DW-1:0] s_data, m_data, ram_wr_data, ram_rd_data;
  logic [AW-1:0] ram_addr;
  logic [AW:0]   level;

  logic [DW-1:0] ram_mem [DEPTH];
  logic [DW-1:0] ram_q1, ram_q2;

  logic [DW-1:0] sb[$];
  int            tests_run, tests_failed, accepted;
  logic          pop_seen, pop_known;
  logic [DW-1:0] pop_got, pop_exp;

  spram_ring_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_addr(ram_addr), .ram_wr_en(ram_wr_en), .ram_wr_data(ram_wr_data),
    .ram_rd_data(ram_rd_data), .level(level), .full(full), .empty(empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: read-first, optional output register.
  always @(posedge clk) begin
    if (ram_wr_en) ram_mem[ram_addr] <= ram_wr_data;
    ram_q1 <= ram_mem[ram_addr];
    ram_q2 <= ram_q1;
  end
  assign ram_rd_data = (LAT == 2) ? ram_q2 : ram_q1;

  task automatic sample_and_step();
    pop_seen  = 1'b0;
    pop_known = 1'b0;
    pop_exp   = 'x;
    if (m_valid && m_ready) begin
      pop_seen = 1'b1;
      pop_got  = m_data;
      if (sb.size() > 0) begin
        pop_known = 1'b1;
        pop_exp   = sb.pop_front();
      end
    end
    if (s_valid && s_ready) begin
      sb.push_back(s_data);
      accepted++;
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    sample_and_step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== '0 || level !== '0 || empty !== 1'b1 || full !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_status got m_valid=%b m_data=%h level=%0d empty=%b full=%b want 0 0 0 1 0",
               m_valid, m_data, level, empty, full);
    end
    tests_run++;
    if (ram_wr_en !== 1'b0 || ram_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_ram got wr_en=%b addr=%0d want 0 0", ram_wr_en, ram_addr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    tests_run++;
    if (s_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_s_ready got %b want 1", s_ready);
    end
    sample_and_step();
  endtask

  task automatic test_latency();
    s_valid = 1'b1; s_data = 32'h1234_5678; m_ready = 1'b0;
    #1;
    tests_run++;
    if (s_ready !== 1'b1 || ram_wr_en !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL latency_write got s_ready=%b wr_en=%b want 1 1", s_ready, ram_wr_en);
    end
    sample_and_step();
    s_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      tests_run++;
      if (m_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL latency_early got m_valid=%b at N+%0d want 0", m_valid, k);
      end
      sample_and_step();
    end
    #1;
    tests_run++;
    if (m_valid !== 1'b1 || m_data !== 32'h1234_5678) begin
      tests_failed++;
      $display("[TB] FAIL latency_arrival got m_valid=%b m_data=%h want 1 12345678", m_valid, m_data);
    end
    m_ready = 1'b1;
    sample_and_step();
    m_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    int base, cyc;
    base = accepted;
    cyc  = 0;
    m_ready = 1'b0;
    while (accepted - base < DEPTH + OB && cyc < 1500) begin
      s_valid = 1'b1;
      s_data  = 32'hFFFF_FFFF - 32'(accepted - base);
      step();
      cyc++;
    end
    tests_run++;
    if (accepted - base !== DEPTH + OB) begin
      tests_failed++;
      $display("[TB] FAIL fill_count got %0d words want %0d", accepted - base, DEPTH + OB);
    end
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      s_data  = $urandom();
      #1;
      tests_run++;
      if (s_ready !== 1'b0 || full !== 1'b1 || level !== 11'(DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL fill_full got s_ready=%b full=%b level=%0d want 0 1 %0d", s_ready, full, level, DEPTH);
      end
      sample_and_step();
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 4000) begin
      step();
      cyc++;
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL drain_data got %h want %h", pop_got, pop_exp);
        end
      end
    end
    repeat (2) step();
    tests_run++;
    if (sb.size() != 0 || empty !== 1'b1 || m_valid !== 1'b0 || level !== '0) begin
      tests_failed++;
      $display("[TB] FAIL drain_end got left=%0d empty=%b m_valid=%b level=%0d want 0 1 0 0",
               sb.size(), empty, m_valid, level);
    end
    m_ready = 1'b0;
  endtask

  task automatic test_contention();
    int base, viol, cyc;
    logic prev, cur;
    base = accepted;
    m_ready = 1'b0;
    while (accepted - base < 100) begin
      s_valid = 1'b1;
      s_data  = $urandom();
      step();
    end
    s_valid = 1'b0;
    repeat (5) step();
    viol = 0;
    prev = 1'b0;
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      s_data = $urandom();
      #1;
      cur = ram_wr_en;
      if (i >= 4 && cur === prev) viol++;
      prev = cur;
      sample_and_step();
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL contention_data got %h want %h", pop_got, pop_exp);
        end
      end
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("[TB] FAIL contention_alternate got %0d repeated grants want 0", viol);
    end
    s_valid = 1'b0;
    cyc = 0;
    while (sb.size() > 0 && cyc < 2000) begin
      step();
      cyc++;
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL contention_drain got %h want %h", pop_got, pop_exp);
        end
      end
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL contention_left got %0d words want 0", sb.size());
    end
    m_ready = 1'b0;
  endtask

  task automatic test_wrap_around();
    int target, cyc;
    target = accepted + 3000;
    cyc = 0;
    while ((accepted < target || sb.size() > 0) && cyc < 20000) begin
      s_valid = (accepted < target) && ($urandom_range(0, 3) != 0);
      s_data  = $urandom();
      m_ready = ($urandom_range(0, 2) != 0);
      step();
      cyc++;
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL wrap_data got %h want %h", pop_got, pop_exp);
        end
      end
      tests_run++;
      if (level > 11'(DEPTH) || sb.size() < int'(level) || sb.size() - int'(level) > OB) begin
        tests_failed++;
        $display("[TB] FAIL wrap_level got level=%0d want <=%0d and held=%0d within %0d above it",
                 level, DEPTH, sb.size(), OB);
      end
    end
    tests_run++;
    if (accepted < target || sb.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL wrap_timeout got accepted_short=%0d left=%0d want 0 0", target - accepted, sb.size());
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic test_flush();
    int base;
    base = accepted;
    m_ready = 1'b0;
    while (accepted - base < 500 + OB) begin
      s_valid = 1'b1;
      s_data  = $urandom();
      step();
    end
    s_valid = 1'b0;
    repeat (4) step();
    #1;
    tests_run++;
    if (level !== 11'd500) begin
      tests_failed++;
      $display("[TB] FAIL flush_setup got level=%0d want 500", level);
    end
    m_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (k > 0) #1;
      sample_and_step();
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL flush_pre_data got %h want %h", pop_got, pop_exp);
        end
      end
    end
    flush = 1'b1; s_valid = 1'b1; s_data = $urandom(); m_ready = 1'b0;
    #1;
    tests_run++;
    if (s_ready !== 1'b0 || ram_wr_en !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL flush_cycle got s_ready=%b wr_en=%b want 0 0", s_ready, ram_wr_en);
    end
    sample_and_step();
    flush = 1'b0; s_valid = 1'b0;
    sb.delete();
    #1;
    tests_run++;
    if (level !== '0 || m_valid !== 1'b0 || empty !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_after got level=%0d m_valid=%b empty=%b want 0 0 1", level, m_valid, empty);
    end
    sample_and_step();
    for (int k = 0; k < 4; k++) begin
      #1;
      tests_run++;
      if (m_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_late_data got m_valid=%b want 0", m_valid);
      end
      sample_and_step();
    end
  endtask

  task automatic test_reset_midstream();
    int target, pops, cyc;
    for (int k = 0; k < 40; k++) begin
      s_valid = ($urandom_range(0, 1) != 0);
      s_data  = $urandom();
      m_ready = ($urandom_range(0, 1) != 0);
      step();
      if (pop_seen) begin
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL midreset_pre got %h want %h", pop_got, pop_exp);
        end
      end
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (m_valid !== 1'b0 || m_data !== '0 || level !== '0 || empty !== 1'b1 || full !== 1'b0 ||
        ram_wr_en !== 1'b0 || ram_addr !== '0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs got m_valid=%b m_data=%h level=%0d empty=%b full=%b wr_en=%b addr=%0d want 0 0 0 1 0 0 0",
               m_valid, m_data, level, empty, full, ram_wr_en, ram_addr);
    end
    #2 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    target = accepted + 16;
    pops = 0;
    cyc = 0;
    while (pops < 16 && cyc < 600) begin
      s_valid = (accepted < target) && ($urandom_range(0, 1) != 0);
      s_data  = $urandom();
      m_ready = ($urandom_range(0, 1) != 0);
      step();
      cyc++;
      if (pop_seen) begin
        pops++;
        tests_run++;
        if (!pop_known || pop_got !== pop_exp) begin
          tests_failed++;
          $display("[TB] FAIL midreset_stream got %h want %h", pop_got, pop_exp);
        end
      end
    end
    tests_run++;
    if (pops != 16) begin
      tests_failed++;
      $display("[TB] FAIL midreset_count got %0d words want 16", pops);
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    accepted = 0;
    test_reset();
    test_latency();
    test_fill_drain();
    test_contention();
    test_wrap_around();
    test_flush();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
